signal_sync_filter: RTL and testbench
=====================================

// Module: signal_sync_filter
// PURPOSE
//   Multi-channel synchroniser for asynchronous level inputs (pins, flags from foreign clock domains) into clk.
//   Per channel: STAGES-deep sync shift register, then a stability (debounce) filter, then registered edge detect.
//   Sits between raw async sources and control logic that needs clean levels plus one-cycle rise/fall strobes.
// PARAMETERS
//   WIDTH       1   number of independent channels
//   STAGES      2   synchroniser flops per channel; legal >= 2
//   FILTER_LEN  4   consecutive cycles a new synced value must persist before acceptance; legal >= 1 (1 = no filtering)
//   RESET_VAL   0   WIDTH-bit reset level of sync chain and sig_out
// PORTS
//   clk       in   1      sole clock; all flops posedge clk
//   rst_n     in   1      synchronous reset, active low
//   sig_in    in   WIDTH  asynchronous inputs, no timing relation to clk
//   sig_out   out  WIDTH  synchronised, filtered levels
//   rise      out  WIDTH  one-cycle pulse when sig_out[i] goes 0->1
//   fall      out  WIDTH  one-cycle pulse when sig_out[i] goes 1->0
//   any_edge  out  1      registered OR of all rise|fall bits, same cycle as them
// BEHAVIOUR
//   Reset (rst_n low at posedge): sync chain and sig_out <= RESET_VAL, counters <= 0, rise/fall/any_edge <= 0.
//   Reset mid-operation discards in-progress filter counts; no pulse is emitted by reset itself.
//   After release, an input differing from RESET_VAL is processed normally and yields an edge after full latency.
//   Sync: sync[0] <= sig_in[i]; sync[k] <= sync[k-1]; s = sync[STAGES-1]. No logic between sync flops.
//   Filter per channel, counter cnt width clog2(FILTER_LEN), each posedge (not in reset):
//     s == sig_out[i]           : cnt <= 0
//     s != sig_out[i], cnt == FILTER_LEN-1 : sig_out[i] <= s, cnt <= 0, rise/fall[i] <= 1 per direction
//     s != sig_out[i], otherwise : cnt <= cnt+1
//   rise/fall are 0 in every cycle not listed above; pulse coincides with the cycle sig_out changes.
//   Latency: sig_in step settled before edge 1 -> s changes after edge STAGES -> sig_out/pulse after edge STAGES+FILTER_LEN.
//   Glitch rejection: any excursion of s shorter than FILTER_LEN cycles never reaches sig_out; counter restarts.
//   A run that returns to sig_out's value at cnt == FILTER_LEN-1 is rejected (compare uses current s).
//   Counter never exceeds FILTER_LEN-1 (no wrap). FILTER_LEN == 1: sig_out follows s with one cycle delay.
//   rise and fall for one channel are mutually exclusive; different channels may pulse in the same cycle.
//   Max sig_out toggle rate per channel: once per FILTER_LEN cycles.
//   Metastability: only sync[0] may go metastable; downstream logic reads s only.
// STRUCTURE
//   Package signal_sync_pkg: clog2 function, SYNC_STAGES_MIN = 2, FILTER_LEN_MIN = 1.
//   Sub-module signal_sync_filter_ch: one channel (sync chain, counter, sig_out, rise, fall),
//     instantiated WIDTH times via generate; top adds any_edge register and parameter range checks.
//   Sync flops carry ASYNC_REG / no-SRL attributes to keep them adjacent and out of shift-register inference.
// TESTING
//   1 Reset: rst_n=0 3 cycles with sig_in=all 1s, RESET_VAL=0 -> sig_out=0, no pulses; release -> rise after 2+4 edges.
//   2 Step: WIDTH=4, sig_in[2] 0->1 before edge 1 -> sig_out[2]=1 and rise[2]=1 exactly at edge 6, one cycle, any_edge=1.
//   3 Glitch: sig_in[0] high for 3 clk cycles (FILTER_LEN=4) -> sig_out, rise, fall stay 0; 4 cycles -> accepted.
//   4 Simultaneous: sig_in[1] rises and sig_in[3] falls same cycle -> rise[1], fall[3] same cycle, single any_edge.
//   5 Reset mid-filter: sig_in[0] high, rst_n low at cnt=2 for 1 cycle -> edge delayed to full 6 cycles after release.
//   6 FILTER_LEN=1, STAGES=3: 1-cycle-wide sync pulse -> sig_out toggles 1 then 0, rise then fall on consecutive cycles.

Source files
------------

// File: rtl/signal_sync_pkg.sv
// Shared constants and helpers for the signal synchroniser / debounce filter.
package signal_sync_pkg;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int FILTER_LEN_MIN  = 1;

   // Smallest r with 2**r >= n; returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Counter width that is never zero, so FILTER_LEN == 1 still yields a legal vector.
   function automatic int cnt_width(input int filter_len);
      return (clog2(filter_len) > 0) ? clog2(filter_len) : 1;
   endfunction

endpackage

// File: rtl/signal_sync_filter_ch.sv
// One channel: synchroniser chain, stability filter and registered edge strobes.
import signal_sync_pkg::*;

module signal_sync_filter_ch #(
   parameter int   STAGES     = 2,
   parameter int   FILTER_LEN = 4,
   parameter logic RESET_VAL  = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic sig_out,
   output logic rise,
   output logic fall,
   output logic accept
);

   localparam int               CNT_W   = cnt_width(FILTER_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

   // Only sync[0] may go metastable; keep the chain together and out of SRLs.
   (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
   logic [STAGES-1:0] sync;
   logic [CNT_W-1:0]  cnt;
   logic              s;

   assign s = sync[STAGES-1];

   // Combinational "value will be accepted this edge"; lets the top register any_edge
   // in the same cycle as rise/fall.
   assign accept = (s != sig_out) && (cnt == CNT_MAX);

   // Plain shift chain, no logic between the flops.
   always_ff @(posedge clk) begin
      if (!rst_n) sync <= {STAGES{RESET_VAL}};
      else        sync <= {sync[STAGES-2:0], sig_in};
   end

   // Stability filter: a new value must persist FILTER_LEN cycles; strobes mark the change.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_out <= RESET_VAL;
         cnt     <= '0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (s == sig_out) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            sig_out <= s;
            cnt     <= '0;
            rise    <= s;
            fall    <= ~s;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/signal_sync_filter.sv
// Multi-channel synchroniser with debounce filter and rise/fall/any_edge strobes.
import signal_sync_pkg::*;

module signal_sync_filter #(
   parameter int               WIDTH      = 1,
   parameter int               STAGES     = 2,
   parameter int               FILTER_LEN = 4,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sig_in,
   output logic [WIDTH-1:0] sig_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             any_edge
);

   logic [WIDTH-1:0] accept;

   generate
      if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
         $error("signal_sync_filter: STAGES must be >= %0d", SYNC_STAGES_MIN);
      end
      if (FILTER_LEN < FILTER_LEN_MIN) begin : g_bad_filter
         $error("signal_sync_filter: FILTER_LEN must be >= %0d", FILTER_LEN_MIN);
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_ch
         signal_sync_filter_ch #(
            .STAGES     (STAGES),
            .FILTER_LEN (FILTER_LEN),
            .RESET_VAL  (RESET_VAL[i])
         ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .sig_in  (sig_in[i]),
            .sig_out (sig_out[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .accept  (accept[i])
         );
      end
   endgenerate

   // Registered OR of all channel strobes, aligned with rise/fall.
   always_ff @(posedge clk) begin
      if (!rst_n) any_edge <= 1'b0;
      else        any_edge <= |accept;
   end

endmodule

// File: tb/tb_signal_sync_filter.sv
// Directed bench: 4-channel default-filter instance plus a 1-channel FILTER_LEN=1/STAGES=3 instance.
module tb_signal_sync_filter;

   logic       clk;
   logic       rst_n;
   logic [3:0] a_in, a_out, a_rise, a_fall;
   logic       a_any;
   logic [0:0] b_in, b_out, b_rise, b_fall;
   logic       b_any;

   int checks = 0;
   int errors = 0;

   signal_sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(4'h0)) dut_a (
      .clk(clk), .rst_n(rst_n), .sig_in(a_in), .sig_out(a_out),
      .rise(a_rise), .fall(a_fall), .any_edge(a_any)
   );

   signal_sync_filter #(.WIDTH(1), .STAGES(3), .FILTER_LEN(1), .RESET_VAL(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .sig_in(b_in), .sig_out(b_out),
      .rise(b_rise), .fall(b_fall), .any_edge(b_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_in  = 4'hF;
      b_in  = 1'b0;
      for (int k = 0; k < 3; k++) step();
      checks++;
      if (a_out !== 4'h0 || a_rise !== 4'h0 || a_fall !== 4'h0 || a_any !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold out=%b rise=%b fall=%b any=%b exp 0000/0000/0000/0", a_out, a_rise, a_fall, a_any);
      end
      checks++;
      if (b_out !== 1'b0 || b_rise !== 1'b0 || b_fall !== 1'b0 || b_any !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold_b out=%b rise=%b fall=%b any=%b exp 0", b_out, b_rise, b_fall, b_any);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         checks++;
         if (a_out !== ((k >= 6) ? 4'hF : 4'h0) || a_rise !== ((k == 6) ? 4'hF : 4'h0) ||
             a_any !== (k == 6) || a_fall !== 4'h0) begin
            errors++;
            $display("FAIL reset_release k=%0d out=%b rise=%b fall=%b any=%b", k, a_out, a_rise, a_fall, a_any);
         end
      end
      a_in = 4'h0;
      for (int k = 1; k <= 7; k++) begin
         step();
         checks++;
         if (a_out !== ((k >= 6) ? 4'h0 : 4'hF) || a_fall !== ((k == 6) ? 4'hF : 4'h0) ||
             a_any !== (k == 6) || a_rise !== 4'h0) begin
            errors++;
            $display("FAIL reset_return k=%0d out=%b rise=%b fall=%b any=%b", k, a_out, a_rise, a_fall, a_any);
         end
      end
   endtask

   task automatic test_step();
      a_in = 4'b0100;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++;
         if (a_out !== ((k >= 6) ? 4'b0100 : 4'b0000) || a_rise !== ((k == 6) ? 4'b0100 : 4'b0000) ||
             a_fall !== 4'h0 || a_any !== (k == 6)) begin
            errors++;
            $display("FAIL step k=%0d out=%b rise=%b fall=%b any=%b", k, a_out, a_rise, a_fall, a_any);
         end
      end
   endtask

   task automatic test_glitch();
      a_in = 4'b0101;
      for (int k = 1; k <= 10; k++) begin
         if (k == 4) a_in = 4'b0100;
         step();
         checks++;
         if (a_out !== 4'b0100 || a_rise !== 4'h0 || a_fall !== 4'h0 || a_any !== 1'b0) begin
            errors++;
            $display("FAIL glitch3 k=%0d out=%b rise=%b fall=%b any=%b exp out 0100 no pulses", k, a_out, a_rise, a_fall, a_any);
         end
      end
      a_in = 4'b0101;
      for (int k = 1; k <= 12; k++) begin
         if (k == 5) a_in = 4'b0100;
         step();
         checks++;
         if (a_out !== ((k >= 6 && k <= 9) ? 4'b0101 : 4'b0100) ||
             a_rise !== ((k == 6) ? 4'b0001 : 4'b0000) ||
             a_fall !== ((k == 10) ? 4'b0001 : 4'b0000) ||
             a_any !== (k == 6 || k == 10)) begin
            errors++;
            $display("FAIL glitch4 k=%0d out=%b rise=%b fall=%b any=%b", k, a_out, a_rise, a_fall, a_any);
         end
      end
   endtask

   task automatic test_simultaneous();
      a_in = 4'b1100;
      for (int k = 0; k < 8; k++) step();
      checks++;
      if (a_out !== 4'b1100) begin
         errors++;
         $display("FAIL simul_setup out=%b exp 1100", a_out);
      end
      a_in = 4'b0110;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++;
         if (a_out !== ((k >= 6) ? 4'b0110 : 4'b1100) ||
             a_rise !== ((k == 6) ? 4'b0010 : 4'b0000) ||
             a_fall !== ((k == 6) ? 4'b1000 : 4'b0000) || a_any !== (k == 6)) begin
            errors++;
            $display("FAIL simul k=%0d out=%b rise=%b fall=%b any=%b", k, a_out, a_rise, a_fall, a_any);
         end
      end
   endtask

   task automatic test_reset_mid();
      a_in = 4'b0111;
      for (int k = 0; k < 4; k++) step();
      rst_n = 1'b0;
      step();
      checks++;
      if (a_out !== 4'h0 || a_rise !== 4'h0 || a_fall !== 4'h0 || a_any !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_hold out=%b rise=%b fall=%b any=%b exp all 0", a_out, a_rise, a_fall, a_any);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         checks++;
         if (a_out !== ((k >= 6) ? 4'b0111 : 4'b0000) || a_rise !== ((k == 6) ? 4'b0111 : 4'b0000) ||
             a_fall !== 4'h0 || a_any !== (k == 6)) begin
            errors++;
            $display("FAIL reset_mid k=%0d out=%b rise=%b fall=%b any=%b", k, a_out, a_rise, a_fall, a_any);
         end
      end
   endtask

   task automatic test_fast_filter();
      b_in = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 1) b_in = 1'b0;
         checks++;
         if (b_out !== (k == 4) || b_rise !== (k == 4) || b_fall !== (k == 5) || b_any !== (k == 4 || k == 5)) begin
            errors++;
            $display("FAIL fast k=%0d out=%b rise=%b fall=%b any=%b", k, b_out, b_rise, b_fall, b_any);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      a_in  = 4'h0;
      b_in  = 1'b0;
      #1;
      test_reset();
      test_step();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      test_fast_filter();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
